// File: rtl/bcd_calendar_counter.sv
// ---------------------------------------------------------------------------
// bcd_calendar_counter
//   Clocked, loadable BCD date keeper for the RTC path. Holds day, month,
//   an N-digit BCD year and the day of week, and advances one day per tick
//   using the Gregorian leap rule for February.
//
// Parameters
//   YEAR_DIGITS  number of BCD year digits (4..8)
//   RESET_YEAR   BCD year after reset, zero-extended to the year width
//   RESET_DOW    day of week after reset (0=Sun .. 6=Sat)
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   tick       advance one day this cycle
//   load       load date from ld_* this cycle (priority over tick)
//   ld_day     BCD day {tens,ones}
//   ld_month   BCD month {tens,ones}
//   ld_year    BCD year, digit 0 in [3:0]
//   ld_dow     day of week 0..6
//   day        current BCD day 01..31
//   month      current BCD month 01..12
//   year       current BCD year
//   dow        current day of week
//   leap_year  current year is a leap year (combinational from year)
//   year_wrap  one-cycle pulse when the year rolls from all-9s to all-0s
//   load_err   one-cycle pulse when a load request is rejected
// ---------------------------------------------------------------------------
module bcd_calendar_counter #(
    parameter int          YEAR_DIGITS = 4,
    parameter logic [15:0] RESET_YEAR  = 16'h2000,
    parameter logic [2:0]  RESET_DOW   = 3'd6
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     tick,
    input  logic                     load,
    input  logic [7:0]               ld_day,
    input  logic [7:0]               ld_month,
    input  logic [4*YEAR_DIGITS-1:0] ld_year,
    input  logic [2:0]               ld_dow,
    output logic [7:0]               day,
    output logic [7:0]               month,
    output logic [4*YEAR_DIGITS-1:0] year,
    output logic [2:0]               dow,
    output logic                     leap_year,
    output logic                     year_wrap,
    output logic                     load_err
);

    localparam int YW = 4 * YEAR_DIGITS;
    localparam logic [YW-1:0] RESET_YEAR_EXT = YW'(RESET_YEAR);

    // Two-digit BCD value divisible by 4: even tens need ones 0/4/8,
    // odd tens need ones 2/6.
    function automatic logic bcd_div4(input logic [7:0] b);
        logic r;
        if (b[4] == 1'b0) begin
            r = (b[3:0] == 4'd0) || (b[3:0] == 4'd4) || (b[3:0] == 4'd8);
        end else begin
            r = (b[3:0] == 4'd2) || (b[3:0] == 4'd6);
        end
        return r;
    endfunction

    // Gregorian leap test using only the low four year digits.
    function automatic logic is_leap(input logic [YW-1:0] y);
        logic r;
        if (y[7:0] != 8'h00) begin
            r = bcd_div4(y[7:0]);
        end else begin
            r = bcd_div4(y[15:8]);
        end
        return r;
    endfunction

    // Month length in BCD; unknown months fall back to 31 and are filtered
    // elsewhere (loads validate the month separately).
    function automatic logic [7:0] month_len(input logic [7:0] m, input logic leap);
        logic [7:0] r;
        case (m)
            8'h04, 8'h06, 8'h09, 8'h11: r = 8'h30;
            8'h02:                      r = leap ? 8'h29 : 8'h28;
            default:                    r = 8'h31;
        endcase
        return r;
    endfunction

    // Two-digit BCD increment (callers never pass 99).
    function automatic logic [7:0] bcd2_inc(input logic [7:0] b);
        logic [7:0] r;
        if (b[3:0] == 4'd9) begin
            r = {b[7:4] + 4'd1, 4'd0};
        end else begin
            r = {b[7:4], b[3:0] + 4'd1};
        end
        return r;
    endfunction

    // N-digit BCD increment with ripple carry; MSB of the result is the
    // carry out of the top digit (all-9s rollover).
    function automatic logic [YW:0] year_inc(input logic [YW-1:0] y);
        logic [YW-1:0] r;
        logic          c;
        r = y;
        c = 1'b1;
        for (int i = 0; i < YEAR_DIGITS; i++) begin
            if (c && (y[4*i +: 4] == 4'd9)) begin
                r[4*i +: 4] = 4'd0;
            end else if (c) begin
                r[4*i +: 4] = y[4*i +: 4] + 4'd1;
                c = 1'b0;
            end else begin
                r[4*i +: 4] = y[4*i +: 4];
            end
        end
        return {c, r};
    endfunction

    // Every BCD digit of an N-digit value is 0..9.
    function automatic logic year_digits_ok(input logic [YW-1:0] y);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < YEAR_DIGITS; i++) begin
            if (y[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end else begin
                ok = ok;
            end
        end
        return ok;
    endfunction

    logic [7:0]    day_r, month_r;
    logic [YW-1:0] year_r;
    logic [2:0]    dow_r;
    logic          year_wrap_r, load_err_r;

    logic [7:0]    day_s, month_s;
    logic [YW-1:0] year_s;
    logic [2:0]    dow_s;
    logic          year_wrap_s, load_err_s;

    logic          cur_leap_s, ld_leap_s, ld_ok_s;
    logic [7:0]    cur_len_s, ld_len_s;
    logic [YW:0]   year_inc_s;

    assign cur_leap_s = is_leap(year_r);
    assign cur_len_s  = month_len(month_r, cur_leap_s);
    assign year_inc_s = year_inc(year_r);

    assign ld_leap_s = is_leap(ld_year);
    assign ld_len_s  = month_len(ld_month, ld_leap_s);
    // Digit checks come first so the numeric BCD compares below are meaningful.
    assign ld_ok_s   = (ld_day[7:4] <= 4'd9) && (ld_day[3:0] <= 4'd9) &&
                       (ld_month[7:4] <= 4'd9) && (ld_month[3:0] <= 4'd9) &&
                       year_digits_ok(ld_year) &&
                       (ld_month >= 8'h01) && (ld_month <= 8'h12) &&
                       (ld_day >= 8'h01) && (ld_day <= ld_len_s) &&
                       (ld_dow <= 3'd6);

    // Next-state: load beats tick; a tick on the last day of the month rolls
    // the month, and on 31-12 also ripples the year.
    always_comb begin
        day_s       = day_r;
        month_s     = month_r;
        year_s      = year_r;
        dow_s       = dow_r;
        year_wrap_s = 1'b0;
        load_err_s  = 1'b0;
        if (load) begin
            if (ld_ok_s) begin
                day_s   = ld_day;
                month_s = ld_month;
                year_s  = ld_year;
                dow_s   = ld_dow;
            end else begin
                load_err_s = 1'b1;
            end
        end else if (tick) begin
            if (day_r < cur_len_s) begin
                day_s = bcd2_inc(day_r);
            end else begin
                day_s = 8'h01;
                if (month_r < 8'h12) begin
                    month_s = bcd2_inc(month_r);
                end else begin
                    month_s     = 8'h01;
                    year_s      = year_inc_s[YW-1:0];
                    year_wrap_s = year_inc_s[YW];
                end
            end
            dow_s = (dow_r >= 3'd6) ? 3'd0 : (dow_r + 3'd1);
        end else begin
            day_s = day_r;
        end
    end

    // Date state and status pulses.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            day_r       <= 8'h01;
            month_r     <= 8'h01;
            year_r      <= RESET_YEAR_EXT;
            dow_r       <= RESET_DOW;
            year_wrap_r <= 1'b0;
            load_err_r  <= 1'b0;
        end else begin
            day_r       <= day_s;
            month_r     <= month_s;
            year_r      <= year_s;
            dow_r       <= dow_s;
            year_wrap_r <= year_wrap_s;
            load_err_r  <= load_err_s;
        end
    end

    assign day       = day_r;
    assign month     = month_r;
    assign year      = year_r;
    assign dow       = dow_r;
    assign leap_year = cur_leap_s;
    assign year_wrap = year_wrap_r;
    assign load_err  = load_err_r;

endmodule
